// File: rtl/par_serializer_pkg.sv
// Shared definitions for the parallel-to-serial converter: FSM state
// encoding and the constant function used to size the bit counter.
package par_serializer_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Number of bits needed to index 0..value-1 (value >= 2).
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/par_serializer.sv
// Parallel-to-serial converter. Accepts a WIDTH-bit word over a
// valid/ready handshake and emits it LSB first, one bit per accepted
// serial transfer. The last bit of a word can overlap with loading the
// next word, so back-to-back words stream without a gap.
module par_serializer
    import par_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
);

    localparam int CNT_W = clog2_f(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0] SH_ZERO  = {WIDTH{1'b0}};

    state_e           state_r;
    state_e           state_next_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    logic             cnt_last_s;
    logic             in_ready_s;
    logic             load_s;
    logic             xfer_s;
    logic             shifting_s;

    // Handshake qualifiers derived from the current state and counter.
    always_comb begin
        shifting_s = (state_r == SHIFT);
        cnt_last_s = (cnt_r == CNT_MAX);
        if (shifting_s) begin
            in_ready_s = out_ready && cnt_last_s;
        end else begin
            in_ready_s = 1'b1;
        end
        load_s = in_valid && in_ready_s;
        xfer_s = shifting_s && out_ready;
    end

    // Next-state, shift register and counter update rules.
    always_comb begin
        state_next_s = state_r;
        shreg_next_s = shreg_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (load_s) begin
                    shreg_next_s = in_data;
                    cnt_next_s   = CNT_ZERO;
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (xfer_s) begin
                    if (cnt_last_s) begin
                        if (load_s) begin
                            // Final bit leaves while the next word arrives.
                            shreg_next_s = in_data;
                            cnt_next_s   = CNT_ZERO;
                            state_next_s = SHIFT;
                        end else begin
                            shreg_next_s = SH_ZERO;
                            cnt_next_s   = CNT_ZERO;
                            state_next_s = IDLE;
                        end
                    end else begin
                        shreg_next_s = {1'b0, shreg_r[WIDTH-1:1]};
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end else begin
                    // Sink stalled: everything holds.
                    state_next_s = SHIFT;
                end
            end
            default: begin
                shreg_next_s = SH_ZERO;
                cnt_next_s   = CNT_ZERO;
                state_next_s = IDLE;
            end
        endcase
    end

    // State, shift register and counter registers; reset aborts any word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            shreg_r <= SH_ZERO;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_next_s;
            shreg_r <= shreg_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Output decode straight from the registered state; quiet when idle.
    always_comb begin
        in_ready = in_ready_s;
        busy     = shifting_s;
        if (shifting_s) begin
            out_valid = 1'b1;
            out_bit   = shreg_r[0];
            out_last  = cnt_last_s;
        end else begin
            out_valid = 1'b0;
            out_bit   = 1'b0;
            out_last  = 1'b0;
        end
    end

endmodule
